// File: rtl/alu_mux_pkg.sv
// Shared types for the pipelined ALU/OR result mux: op encoding and default width.
package alu_mux_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/alu_mux_core.sv
// Combinational ALU/OR select with optional saturation; zero comes from the final result.
// No state, no handshake: the caller registers the outputs.
module alu_mux_core
    import alu_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SAT   = 0
) (
    input  logic             x,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = a - b;
        borrow = (a < b);
        result = a | b;
        carry  = 1'b0;
        if (x) begin
            case (op)
                OP_AND: result = a & b;
                OP_ADD: begin
                    carry  = sum[WIDTH];
                    result = ((SAT != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                end
                OP_SUB: begin
                    carry  = borrow;
                    result = ((SAT != 0) && borrow) ? '0 : diff;
                end
                default: result = a ^ b;
            endcase
        end
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_mux_pipe.sv
// Two-stage pipelined ALU/OR mux: 2-cycle latency, 1 beat/cycle, valid/ready with
// full backpressure (stalled output holds, full pipe drops in_ready); counts output handshakes.
module alu_mux_pipe
    import alu_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic             x;
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    logic             s1_valid;
    s1_t              s1_q;
    logic             s2_adv;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_zero;

    assign s2_adv   = s1_valid & (!out_valid | out_ready);
    assign in_ready = !s1_valid | s2_adv;

    // When in_ready is high, S1 is either empty or draining, so it simply takes in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_q <= '{x: x, op: op_e'(op), a: a, b: b};
            end
        end
    end

    alu_mux_core #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_core (
        .x      (s1_q.x),
        .op     (s1_q.op),
        .a      (s1_q.a),
        .b      (s1_q.b),
        .result (core_result),
        .carry  (core_carry),
        .zero   (core_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            result    <= core_result;
            carry     <= core_carry;
            zero      <= core_zero;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (out_valid && out_ready) begin
            count <= count + 1'b1;
        end
    end

endmodule
